vr_fifo: RTL and testbench

VR_FIFO -- requirements
Module: vr_fifo

---
 rtl/vr_fifo.sv | 98 +++++++++
 tb/tb_vr_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vr_fifo.sv
// First-word-fall-through FIFO with valid/ready output, sticky overflow and drop counter.
// Define VR_FIFO_DROP_CNT_EN to build the saturating drop counter; otherwise drop_cnt is 0.
module vr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
    end else begin
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef VR_FIFO_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (ovf_clr) begin
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_vr_fifo.sv
// Self-checking bench for vr_fifo: constant vector table plus queue scoreboard sequences.
module tb_vr_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [2:0]       level;
  logic             overflow;
  logic             ovf_clr;
  logic [7:0]       drop_cnt;

  vr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  logic [7:0] q[$];
  bit movf = 1'b0;
  int mcnt = 0;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       rdy;
    logic       clr;
    logic [2:0] lvl;
    logic       vld;
    logic [7:0] head;
    logic       ovf;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk); #1;
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_cnt", drop_cnt, 0);
    rst = 1'b0;
    q.delete(); movf = 1'b0; mcnt = 0;
    @(posedge clk); #1;
  endtask

  // Drive one cycle, compare registered outputs against the model, then update the model.
  task automatic cycle(input logic iv, input logic [7:0] d, input logic rdy, input logic clr);
    bit mfull, mpop, mdrop;
    in_valid = iv; in_data = d; out_ready = rdy; ovf_clr = clr;
    #1;
    chk("level", level, q.size());
    chk("valid", out_valid, (q.size() != 0));
    chk("ovf", overflow, movf);
    chk("cnt", drop_cnt, mcnt);
    if (q.size() != 0) chk("head", out_data, q[0]);
    mfull = (q.size() == DEPTH);
    mpop  = (q.size() != 0) && rdy;
    mdrop = iv && mfull && !mpop;
    if (mpop) begin
      void'(q.pop_front());
      popped++;
    end
    if (iv && !mdrop) q.push_back(d);
    if (mdrop) movf = 1'b1;
    else if (clr) movf = 1'b0;
`ifdef VR_FIFO_DROP_CNT_EN
    if (clr) mcnt = mdrop ? 1 : 0;
    else if (mdrop && mcnt < 255) mcnt++;
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 8'h11, 1'b0};
    vt[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0};
    vt[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0};
    vt[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0};
    vt[4]  = '{1'b1, 8'h55, 1'b1, 1'b0, 3'd4, 1'b1, 8'h22, 1'b0};
    vt[5]  = '{1'b1, 8'h66, 1'b0, 1'b0, 3'd4, 1'b1, 8'h22, 1'b1};
    vt[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 8'h22, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h33, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h44, 1'b0};
    vt[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h55, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
    vt[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(vt[i].iv, vt[i].d, vt[i].rdy, vt[i].clr);
      chk($sformatf("tbl%0d_level", i), level, vt[i].lvl);
      chk($sformatf("tbl%0d_valid", i), out_valid, vt[i].vld);
      chk($sformatf("tbl%0d_ovf", i), overflow, vt[i].ovf);
      if (vt[i].vld) chk($sformatf("tbl%0d_head", i), out_data, vt[i].head);
    end

    // Six words into four entries: two drops, then ordered drain.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    chk("ovr_level", level, 4);
    chk("ovr_flag", overflow, 1);
`ifdef VR_FIFO_DROP_CNT_EN
    chk("ovr_cnt", drop_cnt, 2);
`else
    chk("ovr_cnt", drop_cnt, 0);
`endif
    popped = 0;
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovr_drained", popped, 4);

    // Full with simultaneous push and pop keeps the word.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("fullpp_level", level, 4);
    chk("fullpp_ovf", overflow, 0);
    chk("fullpp_head", out_data, 8'hC1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming with pointer wrap.
    do_reset();
    popped = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 8'(i), 1'b1, 1'b0);
      chk("stream_level_le1", (level <= 3'd1), 1);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("stream_popped", popped, 20);
    chk("stream_empty", out_valid, 0);

    // Asynchronous reset pulse between clock edges.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    chk("pre_arst_level", level, 3);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_level", level, 0);
    rst = 1'b0;
    q.delete(); movf = 1'b0; mcnt = 0;
    @(posedge clk); #1;
    cycle(1'b1, 8'h7E, 1'b0, 1'b0);
    chk("arst_head", out_data, 8'h7E);
    chk("arst_head_valid", out_valid, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // Drop coinciding with ovf_clr: set wins, counter restarts at 1.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    chk("clr_pre_ovf", overflow, 1);
    cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 1);
`ifdef VR_FIFO_DROP_CNT_EN
    chk("clr_cnt", drop_cnt, 1);
`else
    chk("clr_cnt", drop_cnt, 0);
`endif
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_only_ovf", overflow, 0);
    chk("clr_only_cnt", drop_cnt, 0);

    // Counter saturation.
    for (int i = 0; i < 260; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
`ifdef VR_FIFO_DROP_CNT_EN
    chk("sat_cnt", drop_cnt, 255);
`else
    chk("sat_cnt", drop_cnt, 0);
`endif
    chk("sat_level", level, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
